melody_sequencer: RTL and testbench

//  Sequences the buzzer tone divider from a note score held in an external synchronous ROM.

---
 rtl/melody_sequencer_if.sv | 26 ++
 rtl/melody_sequencer.sv | 175 +++++++++++++++++
 tb/tb_melody_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/melody_sequencer_if.sv
// Bus between the melody sequencer, its controller, the score ROM and the tone divider.
interface melody_sequencer_if #(
  parameter int AW = 8
);
  // start/stop are single-cycle pulses, pause/loop_en are levels; rom_data answers rom_addr one clk later.
  logic          start;
  logic          stop;
  logic          pause;
  logic          loop_en;
  logic [AW-1:0] rom_addr;
  logic [19:0]   rom_data;
  logic [15:0]   tone_hp;
  logic          tone_en;
  logic          busy;
  logic          done;

  modport master (
    output start, stop, pause, loop_en, rom_data,
    input  rom_addr, tone_hp, tone_en, busy, done
  );

  modport slave (
    input  start, stop, pause, loop_en, rom_data,
    output rom_addr, tone_hp, tone_en, busy, done
  );
endinterface

// File: rtl/melody_sequencer.sv
// Walks a {dur, hp} score ROM and drives the buzzer divider note by note, with a silent
// gap after each note, plus start/stop/pause/loop control.
module melody_sequencer #(
  parameter int TICK_DIV = 6250000,
  parameter int GAP_CYC  = 250000,
  parameter int AW       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  melody_sequencer_if.slave        io_bus,
  output logic [2:0]               o_dbg_state
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_wrap, w_wrap_nxt;
  logic [15:0]   r_hp, w_hp_nxt;
  logic [3:0]    r_dur, w_dur_nxt;
  logic [PW-1:0] r_presc, w_presc_nxt;
  logic [GW-1:0] r_gap, w_gap_nxt;
  logic [15:0]   r_tone_hp, w_tone_hp_nxt;
  logic          r_tone_en, w_tone_en_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic [3:0]    w_rom_dur;
  logic [15:0]   w_rom_hp;

  assign w_rom_dur = io_bus.rom_data[19:16];
  assign w_rom_hp  = io_bus.rom_data[15:0];

  always_comb begin
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_wrap_nxt    = r_wrap;
    w_hp_nxt      = r_hp;
    w_dur_nxt     = r_dur;
    w_presc_nxt   = r_presc;
    w_gap_nxt     = r_gap;
    w_tone_hp_nxt = r_tone_hp;
    w_tone_en_nxt = r_tone_en;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    if (io_bus.stop) begin
      w_state_nxt   = S_IDLE;
      w_addr_nxt    = '0;
      w_wrap_nxt    = 1'b0;
      w_dur_nxt     = '0;
      w_presc_nxt   = '0;
      w_gap_nxt     = '0;
      w_tone_hp_nxt = '0;
      w_tone_en_nxt = 1'b0;
      w_busy_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            w_state_nxt = S_FETCH;
            w_addr_nxt  = '0;
            w_wrap_nxt  = 1'b0;
            w_busy_nxt  = 1'b1;
          end
        end
        S_FETCH: w_state_nxt = S_LOAD;
        S_LOAD: begin
          // r_wrap marks that the last note sat at the top address; treat it as an end marker.
          if (w_rom_dur == 4'd0 || r_wrap) begin
            if (io_bus.loop_en && (r_addr != '0 || r_wrap)) begin
              w_state_nxt = S_FETCH;
              w_addr_nxt  = '0;
              w_wrap_nxt  = 1'b0;
            end else begin
              w_state_nxt = S_IDLE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_state_nxt   = S_PLAY;
            w_hp_nxt      = w_rom_hp;
            w_dur_nxt     = w_rom_dur;
            w_tone_hp_nxt = w_rom_hp;
            w_tone_en_nxt = (w_rom_hp != 16'd0);
            w_presc_nxt   = '0;
          end
        end
        S_PLAY: begin
          if (io_bus.pause) begin
            w_tone_hp_nxt = '0;
            w_tone_en_nxt = 1'b0;
          end else begin
            w_tone_hp_nxt = r_hp;
            w_tone_en_nxt = (r_hp != 16'd0);
            if (r_presc == PW'(TICK_DIV - 1)) begin
              w_presc_nxt = '0;
              if (r_dur == 4'd1) begin
                w_dur_nxt     = '0;
                w_tone_hp_nxt = '0;
                w_tone_en_nxt = 1'b0;
                if (GAP_CYC > 0) begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = '0;
                end else begin
                  w_state_nxt = S_FETCH;
                  w_addr_nxt  = r_addr + AW'(1);
                  w_wrap_nxt  = &r_addr;
                end
              end else begin
                w_dur_nxt = r_dur - 4'd1;
              end
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
          end
        end
        S_GAP: begin
          if (!io_bus.pause) begin
            if (r_gap == GW'(GAP_CYC - 1)) begin
              w_state_nxt = S_FETCH;
              w_gap_nxt   = '0;
              w_addr_nxt  = r_addr + AW'(1);
              w_wrap_nxt  = &r_addr;
            end else begin
              w_gap_nxt = r_gap + GW'(1);
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wrap    <= 1'b0;
      r_hp      <= '0;
      r_dur     <= '0;
      r_presc   <= '0;
      r_gap     <= '0;
      r_tone_hp <= '0;
      r_tone_en <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_addr    <= w_addr_nxt;
      r_wrap    <= w_wrap_nxt;
      r_hp      <= w_hp_nxt;
      r_dur     <= w_dur_nxt;
      r_presc   <= w_presc_nxt;
      r_gap     <= w_gap_nxt;
      r_tone_hp <= w_tone_hp_nxt;
      r_tone_en <= w_tone_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign io_bus.rom_addr = r_addr;
  assign io_bus.tone_hp  = r_tone_hp;
  assign io_bus.tone_en  = r_tone_en;
  assign io_bus.busy     = r_busy;
  assign io_bus.done     = r_done;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle trace of addr/busy/done/tone compared against a
// timeline built from the score (note, gap, fetch slots; pause inserts frozen cycles).
module tb_melody_sequencer;
  localparam int TICK_DIV = 4;
  localparam int GAP_CYC  = 2;
  localparam int AW       = 4;
  localparam int DEPTH    = 16;
  localparam int W        = AW + 3 + 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_state;
  logic [19:0] rom_img [DEPTH];
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  melody_sequencer_if #(.AW(AW)) bus ();

  melody_sequencer #(.TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC), .AW(AW)) dut (
    .clk(clk), .rst(rst), .io_bus(bus), .o_dbg_state(dbg_state)
  );

  always @(posedge clk) bus.rom_data <= rom_img[bus.rom_addr];

  function automatic logic [W-1:0] pack(input int a, input bit b, input bit d, input bit e,
                                        input logic [15:0] h);
    logic [AW-1:0] av;
    av = AW'(a);
    return {av, b, d, e, h};
  endfunction

  // Expected trace, sample k = outputs after the k-th edge following the start edge.
  task automatic build_model(input int n, input bit loop, input int pe, input int pl);
    logic [W-1:0] tr[$];
    logic [W-1:0] prev;
    logic [3:0] d;
    logic [15:0] h;
    int a;
    bit wrapped;
    a = 0;
    wrapped = 0;
    tr.push_back(pack(0, 1, 0, 0, 0));
    tr.push_back(pack(0, 1, 0, 0, 0));
    while (tr.size() < n + pl) begin
      d = rom_img[a][19:16];
      h = rom_img[a][15:0];
      if (d == 0 || wrapped) begin
        if (loop && (a != 0 || wrapped)) begin
          a = 0;
          wrapped = 0;
          tr.push_back(pack(0, 1, 0, 0, 0));
          tr.push_back(pack(0, 1, 0, 0, 0));
        end else begin
          tr.push_back(pack(a, 0, 1, 0, 0));
          while (tr.size() < n + pl) tr.push_back(pack(a, 0, 0, 0, 0));
        end
      end else begin
        for (int k = 0; k < d * TICK_DIV; k++) tr.push_back(pack(a, 1, 0, h != 0, h));
        for (int j = 0; j < GAP_CYC + 2; j++)
          tr.push_back(pack((j < GAP_CYC) ? a : (a + 1) % DEPTH, 1, 0, 0, 0));
        if (a == DEPTH - 1) wrapped = 1;
        a = (a + 1) % DEPTH;
      end
    end
    for (int j = 0; j < pl; j++) begin
      prev = tr[pe - 1];
      tr.insert(pe, pack(int'(prev[W-1 -: AW]), 1, 0, 0, 0));
    end
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(tr[k]);
  endtask

  task automatic run_score(input string name, input int n, input bit loop, input int pe,
                           input int pl, input int again);
    logic [W-1:0] exp_v, act_v;
    build_model(n, loop, pe, pl);
    bus.loop_en = loop;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.rom_addr, bus.busy, bus.done, bus.tone_en, bus.tone_hp};
      n_checks++;
      if (act_v !== exp_v)
        $display("FAIL %s cycle %0d: got addr=%0d busy=%b done=%b en=%b hp=%0d, want addr=%0d busy=%b done=%b en=%b hp=%0d",
                 name, k, act_v[W-1 -: AW], act_v[18], act_v[17], act_v[16], act_v[15:0],
                 exp_v[W-1 -: AW], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
      else
        n_pass++;
      bus.pause = (pl > 0) && (k + 1 >= pe) && (k + 1 < pe + pl);
      bus.start = (k + 1 == again);
      @(negedge clk);
    end
    bus.pause = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic do_stop(input string name);
    logic [W-1:0] act_v;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      act_v = {bus.rom_addr, bus.busy, bus.done, bus.tone_en, bus.tone_hp};
      n_checks++;
      if (act_v !== pack(0, 0, 0, 0, 0))
        $display("FAIL %s +%0d: got addr=%0d busy=%b done=%b en=%b hp=%0d, want all zero",
                 name, k, act_v[W-1 -: AW], act_v[18], act_v[17], act_v[16], act_v[15:0]);
      else
        n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic check_idle_now(input string name);
    logic [W-1:0] act_v;
    act_v = {bus.rom_addr, bus.busy, bus.done, bus.tone_en, bus.tone_hp};
    n_checks++;
    if (act_v !== pack(0, 0, 0, 0, 0))
      $display("FAIL %s: got addr=%0d busy=%b done=%b en=%b hp=%0d, want all zero",
               name, act_v[W-1 -: AW], act_v[18], act_v[17], act_v[16], act_v[15:0]);
    else
      n_pass++;
  endtask

  task automatic load_basic();
    rom_img[0] = {4'd2, 16'd100};
    rom_img[1] = {4'd1, 16'd0};
    rom_img[2] = {4'd0, 16'($urandom)};
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1 check_idle_now("reset_async");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_now("reset_idle_hold");
  endtask

  task automatic test_basic();
    load_basic();
    run_score("basic", 27, 0, 0, 0, -1);
  endtask

  task automatic test_pause();
    rom_img[0] = {4'd4, 16'd200};
    rom_img[1] = {4'd0, 16'd0};
    run_score("pause", 31, 0, 8, 5, -1);
    run_score("pause_gap", 31, 0, 19, 4, -1);
  endtask

  task automatic test_loop();
    rom_img[0] = {4'd1, 16'd50};
    rom_img[1] = {4'd0, 16'd7};
    run_score("loop", 30, 1, 0, 0, -1);
    do_stop("loop_stop");
    rom_img[0] = {4'd0, 16'd9};
    run_score("empty_loop", 6, 1, 0, 0, -1);
  endtask

  task automatic test_stop();
    rom_img[0] = {4'd4, 16'd300};
    rom_img[1] = {4'd0, 16'd0};
    run_score("stop_pre", 8, 0, 0, 0, -1);
    do_stop("stop_mid_note");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check_idle_now("start_stop_same");
    @(negedge clk);
    check_idle_now("start_stop_after");
  endtask

  task automatic test_async_reset();
    load_basic();
    run_score("arst_pre", 6, 0, 0, 0, -1);
    #2 rst = 1'b1;
    #1 check_idle_now("arst_mid_play");
    @(negedge clk);
    rst = 1'b0;
    run_score("arst_restart", 27, 0, 0, 0, -1);
  endtask

  task automatic test_back_to_back();
    load_basic();
    run_score("start_busy", 27, 0, 0, 0, 10);
    run_score("start_busy_gap", 27, 0, 0, 0, 13);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DEPTH; i++) rom_img[i] = {4'd1, 16'(1000 + i)};
    run_score("wrap_done", 134, 0, 0, 0, -1);
    run_score("wrap_loop", 144, 1, 0, 0, -1);
    do_stop("wrap_stop");
  endtask

  task automatic test_random();
    int len, total, n, pe, pl;
    bit loop;
    logic [3:0] d;
    logic [15:0] h;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(1, 4);
      total = 3;
      for (int i = 0; i < len; i++) begin
        d = 4'($urandom_range(1, 3));
        h = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 65535));
        rom_img[i] = {d, h};
        total += d * TICK_DIV + GAP_CYC + 2;
      end
      rom_img[len] = {4'd0, 16'($urandom)};
      loop = 1'($urandom_range(0, 1));
      pe = 0;
      pl = 0;
      if ($urandom_range(0, 1) == 1) begin
        pe = $urandom_range(3, 2 + rom_img[0][19:16] * TICK_DIV + GAP_CYC);
        pl = $urandom_range(1, 6);
      end
      n = (loop ? 2 * total : total + 3) + pl;
      run_score($sformatf("random%0d", it), n, loop, pe, pl, -1);
      if (loop) do_stop($sformatf("random%0d_stop", it));
    end
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.loop_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) rom_img[i] = '0;
    test_reset();
    test_basic();
    test_pause();
    test_loop();
    test_stop();
    test_async_reset();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
